// File: rtl/float_divider_bf16.sv
// Sequential bfloat16 divider: y = a / b via a 9-step restoring shift-subtract loop,
// with valid/ready handshakes, round-to-nearest-even, wrapping 8-bit exponent.
module float_divider_bf16 #(
  parameter logic [7:0] BIAS = 8'd127,
  parameter int         ITER = 9
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [15:0] a,
  input  logic [15:0] b,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [15:0] y
);

  typedef enum logic [2:0] {IDLE, NORM, DIV, ROUND, DONE} state_t;

  state_t            state;
  logic [15:0]       a_r, b_r;
  logic              sign, za, zb;
  logic [7:0]        exp;
  logic [8:0]        rem;
  // The integer quotient bit is always 1, so only the last ITER-1 bits are kept.
  logic [ITER-2:0]   q;
  logic [3:0]        cnt;

  logic [7:0] ma, mb, exp_base, rem_sub, mant_sum;
  logic       ge, rnd;

  always_comb begin
    ma       = {1'b1, a_r[6:0]};
    mb       = {1'b1, b_r[6:0]};
    exp_base = a_r[14:7] - b_r[14:7] + BIAS;
    ge       = (rem >= {1'b0, mb});
    // rem < 2*mb always holds, so rem - mb fits in 8 bits whenever ge is set.
    rem_sub  = rem[7:0] - mb;
    rnd      = q[0] & ((rem != 9'd0) | q[1]);
    mant_sum = {1'b0, q[7:1]} + {7'd0, rnd};
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state     <= IDLE;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      y         <= 16'h0000;
      a_r       <= 16'h0000;
      b_r       <= 16'h0000;
      sign      <= 1'b0;
      za        <= 1'b0;
      zb        <= 1'b0;
      exp       <= 8'h00;
      rem       <= 9'h000;
      q         <= '0;
      cnt       <= 4'd0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            a_r      <= a;
            b_r      <= b;
            in_ready <= 1'b0;
            state    <= NORM;
          end
        end
        NORM: begin
          sign <= a_r[15] ^ b_r[15];
          za   <= (a_r[14:0] == 15'd0);
          zb   <= (b_r[14:0] == 15'd0);
          if (ma < mb) begin
            rem <= {ma, 1'b0};
            exp <= exp_base - 8'd1;
          end else begin
            rem <= {1'b0, ma};
            exp <= exp_base;
          end
          q     <= '0;
          cnt   <= 4'(ITER - 1);
          state <= DIV;
        end
        DIV: begin
          rem <= ge ? {rem_sub, 1'b0} : {rem[7:0], 1'b0};
          q   <= {q[ITER-3:0], ge};
          cnt <= cnt - 4'd1;
          if (cnt == 4'd0) state <= ROUND;
        end
        ROUND: begin
          if (zb)      y <= {sign, 8'hFF, 7'h00};
          else if (za) y <= {sign, 15'h0000};
          else         y <= {sign, exp + {7'd0, mant_sum[7]}, mant_sum[6:0]};
          out_valid <= 1'b1;
          state     <= DONE;
        end
        DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_float_divider_bf16.sv
// Directed scoreboard bench for float_divider_bf16: expected quotients are queued
// at issue and popped when out_valid appears; latency and handshakes are checked.
module tb_float_divider_bf16;

  logic        clock = 1'b0;
  logic        reset_n = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [15:0] a = 16'h0000;
  logic [15:0] b = 16'h0000;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [15:0] y;

  int n_vec = 0;
  int n_bad = 0;
  logic [15:0] sq[$];

  float_divider_bf16 dut (
    .clock    (clock),
    .reset_n  (reset_n),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .a        (a),
    .b        (b),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .y        (y)
  );

  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Called #1 after a rising edge with the DUT idle; returns #1 after the accept edge.
  task automatic start_op(input logic [15:0] av, input logic [15:0] bv, input logic [15:0] ev);
    check("idle_in_ready", {15'd0, in_ready}, 16'd1);
    a = av;
    b = bv;
    in_valid = 1'b1;
    sq.push_back(ev);
    @(posedge clock);
    #1;
    in_valid = 1'b0;
    check("accept_in_ready_low", {15'd0, in_ready}, 16'd0);
  endtask

  task automatic wait_result(input string tag, input bit perturb);
    int cyc = 0;
    logic [15:0] ev;
    while (!out_valid && cyc < 40) begin
      @(posedge clock);
      #1;
      cyc++;
      if (perturb && !out_valid) begin
        in_valid = cyc[0];
        a = 16'($urandom);
        b = 16'($urandom);
      end
    end
    in_valid = 1'b0;
    check({tag, "_latency"}, 16'(cyc), 16'd11);
    if (sq.size() > 0) ev = sq.pop_front();
    else ev = 16'hxxxx;
    check({tag, "_y"}, y, ev);
  endtask

  task automatic consume();
    out_ready = 1'b1;
    @(posedge clock);
    #1;
    out_ready = 1'b0;
    check("consume_out_valid", {15'd0, out_valid}, 16'd0);
    check("consume_in_ready", {15'd0, in_ready}, 16'd1);
  endtask

  task automatic op(input string tag, input logic [15:0] av, input logic [15:0] bv,
                    input logic [15:0] ev);
    start_op(av, bv, ev);
    wait_result(tag, 1'b0);
    consume();
  endtask

  initial begin
    #2 reset_n = 1'b0;
    #1;
    check("rst_in_ready", {15'd0, in_ready}, 16'd1);
    check("rst_out_valid", {15'd0, out_valid}, 16'd0);
    check("rst_y", y, 16'h0000);
    repeat (2) @(posedge clock);
    #1 reset_n = 1'b1;
    @(posedge clock);
    #1;

    // 1/1 with out_ready already high before the result appears
    out_ready = 1'b1;
    start_op(16'h3F80, 16'h3F80, 16'h3F80);
    wait_result("one_div_one", 1'b0);
    consume();

    op("three_halves", 16'h4040, 16'h4000, 16'h3FC0);
    op("one_third",    16'h3F80, 16'h4040, 16'h3EAB);
    op("six_thirds",   16'h40C0, 16'h4040, 16'h4000);
    op("near_two",     16'h3F80, 16'h3F81, 16'h3F7E);
    op("round_up",     16'h3FFE, 16'h3FFF, 16'h3F7F);
    op("exp_wrap",     16'h0080, 16'h7F00, 16'h4100);
    op("neg_quot",     16'h4040, 16'hC000, 16'hBFC0);
    op("neg_div_zero", 16'hC000, 16'h0000, 16'hFF80);
    op("zero_div_neg", 16'h0000, 16'hC000, 16'h8000);
    op("zero_div_zero",16'h0000, 16'h0000, 16'h7F80);

    // backpressure
    start_op(16'hC0A0, 16'h4020, 16'hC000);
    wait_result("backpressure", 1'b0);
    for (int i = 0; i < 20; i++) begin
      @(posedge clock);
      #1;
      check("bp_y", y, 16'hC000);
      check("bp_out_valid", {15'd0, out_valid}, 16'd1);
      check("bp_in_ready", {15'd0, in_ready}, 16'd0);
    end
    consume();

    // operand and in_valid activity while busy
    start_op(16'h4040, 16'h4000, 16'h3FC0);
    wait_result("busy_ignore", 1'b1);
    consume();
    for (int i = 0; i < 15; i++) begin
      @(posedge clock);
      #1;
      check("no_second_result", {15'd0, out_valid}, 16'd0);
      check("idle_stays_ready", {15'd0, in_ready}, 16'd1);
    end

    // reset in the middle of a divide
    start_op(16'h3F80, 16'h4040, 16'h3EAB);
    repeat (4) @(posedge clock);
    #2 reset_n = 1'b0;
    #1;
    void'(sq.pop_back());
    check("midrst_out_valid", {15'd0, out_valid}, 16'd0);
    check("midrst_in_ready", {15'd0, in_ready}, 16'd1);
    check("midrst_y", y, 16'h0000);
    @(posedge clock);
    #1 reset_n = 1'b1;
    @(posedge clock);
    #1;
    check("post_rst_y", y, 16'h0000);
    op("after_reset", 16'h4040, 16'h4000, 16'h3FC0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
